// File: rtl/sdram_arbiter.sv
// sdram_arbiter: slot-timed single-port SDRAM scheduler that serves the init copier,
// the ROM downloader, refresh and the CPU/Nick port through a request/ack handshake.
//
// Ports:
//   clock, reset              system clock, synchronous active-high reset
//   sdrReady                  sdram initialisation done; no grant is made while low
//   rfshReq                   refresh tick; it sets a refresh-pending flag
//   iniReq/iniA/iniD/iniAck   init copier write port
//   ldReq/ldA/ldD/ldAck       ROM downloader write port
//   cpuRd/cpuWr/cpuA/cpuD     CPU request port
//   cpuQ/cpuAck               registered CPU read data and the CPU ack
//   romTop                    highest ROM page number (used by the write-protect option)
//   rfsh/rd/wr/a/d/q          sdram command strobes, address and data
//   busy                      high whenever the scheduler is not idle
//
// Optional build macro: ARB_WPROT_EN. When it is defined, a CPU write to a ROM page
// (cpuA[AW-1:14] <= romTop) is dropped. The slot still runs and the CPU is still acked.

module sdram_arbiter #(
    parameter int AW    = 22,
    parameter int SLOT  = 4,
    parameter int RFMAX = 3
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          sdrReady,
    input  logic          rfshReq,
    input  logic          iniReq,
    input  logic [AW-1:0] iniA,
    input  logic [7:0]    iniD,
    output logic          iniAck,
    input  logic          ldReq,
    input  logic [AW-1:0] ldA,
    input  logic [7:0]    ldD,
    output logic          ldAck,
    input  logic          cpuRd,
    input  logic          cpuWr,
    input  logic [AW-1:0] cpuA,
    input  logic [7:0]    cpuD,
    output logic [7:0]    cpuQ,
    output logic          cpuAck,
    input  logic [7:0]    romTop,
    output logic          rfsh,
    output logic          rd,
    output logic          wr,
    output logic [23:0]   a,
    output logic [15:0]   d,
    input  logic [15:0]   q,
    output logic          busy
);

    localparam int DW = $clog2(RFMAX + 2);
    localparam logic [DW-1:0] DMAX = DW'(RFMAX);
    localparam logic [3:0] WLAST = 4'(SLOT - 2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_ACK
    } state_t;

    typedef enum logic [2:0] {
        G_NONE,
        G_INI,
        G_LD,
        G_RF,
        G_CRD,
        G_CWR
    } gnt_t;

    state_t        state_q, state_d;
    gnt_t          gnt_q, gnt_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [23:0]   a_q, a_d;
    logic [15:0]   d_q, d_d;
    logic [7:0]    cpuq_q, cpuq_d;
    logic          rpend_q, rpend_d;
    logic [DW-1:0] defer_q, defer_d;
    logic          mask_q, mask_d;
    logic          sup_q, sup_d;

    gnt_t pick;
    logic take;
    logic ini_v, ld_v, cpu_raw, cpu_v, rf_v;
    logic prot;
    logic unused_ok;

`ifdef ARB_WPROT_EN
    localparam int PW = AW - 14;
    assign prot = ({{(32 - PW){1'b0}}, cpuA[AW-1:14]} <= {24'd0, romTop});
    assign unused_ok = ^q[15:8];
`else
    assign prot = 1'b0;
    assign unused_ok = ^{romTop, q[15:8]};
`endif

    // Arbitration. The requester acked in the previous slot is masked for one
    // cycle so a late deassert cannot win a second grant. The refresh-vs-CPU
    // decision uses the raw CPU request, so a masked CPU still defers refresh
    // until the defer budget is spent.
    always_comb begin
        cpu_raw = cpuRd | cpuWr;
        ini_v   = iniReq & ~(mask_q & (gnt_q == G_INI));
        ld_v    = ldReq & ~(mask_q & (gnt_q == G_LD));
        cpu_v   = cpu_raw & ~(mask_q & ((gnt_q == G_CRD) | (gnt_q == G_CWR)));
        rf_v    = rpend_q & (~cpu_raw | (defer_q == DMAX));
        pick    = G_NONE;
        if (!sdrReady) begin
            pick = G_NONE;
        end else if (ini_v) begin
            pick = G_INI;
        end else if (ld_v) begin
            pick = G_LD;
        end else if (rf_v) begin
            pick = G_RF;
        end else if (cpu_v) begin
            pick = cpuWr ? G_CWR : G_CRD;
        end
        take = (state_q == S_IDLE) & (pick != G_NONE);
    end

    // State register and datapath registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            gnt_q   <= G_NONE;
            cnt_q   <= '0;
            a_q     <= '0;
            d_q     <= '0;
            cpuq_q  <= 8'hFF;
            rpend_q <= 1'b0;
            defer_q <= '0;
            mask_q  <= 1'b0;
            sup_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            d_q     <= d_d;
            cpuq_q  <= cpuq_d;
            rpend_q <= rpend_d;
            defer_q <= defer_d;
            mask_q  <= mask_d;
            sup_q   <= sup_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        d_d     = d_q;
        cpuq_d  = cpuq_q;
        defer_d = defer_q;
        sup_d   = sup_q;
        mask_d  = (state_q == S_ACK);

        // A new refresh tick wins over the clear from a same-cycle grant
        rpend_d = rfshReq | (rpend_q & ~(take & (pick == G_RF)));

        case (state_q)
            S_IDLE: begin
                if (take) begin
                    state_d = S_ISSUE;
                    gnt_d   = pick;
                    sup_d   = 1'b0;
                    case (pick)
                        G_INI: begin
                            a_d = {{(24 - AW){1'b0}}, iniA};
                            d_d = {8'h00, iniD};
                        end
                        G_LD: begin
                            a_d = {{(24 - AW){1'b0}}, ldA};
                            d_d = {8'h00, ldD};
                        end
                        G_CRD, G_CWR: begin
                            a_d   = {{(24 - AW){1'b0}}, cpuA};
                            d_d   = {8'h00, cpuD};
                            sup_d = (pick == G_CWR) & prot;
                            if (rpend_q && defer_q != DMAX) begin
                                defer_d = defer_q + 1'b1;
                            end
                        end
                        default: begin
                            a_d     = '0;
                            d_d     = '0;
                            defer_d = '0;
                        end
                    endcase
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
                cnt_d   = '0;
            end
            S_WAIT: begin
                if (cnt_q == WLAST) begin
                    state_d = S_ACK;
                    if (gnt_q == G_CRD) begin
                        cpuq_d = q[7:0];
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode
    always_comb begin
        rfsh   = 1'b0;
        rd     = 1'b0;
        wr     = 1'b0;
        iniAck = 1'b0;
        ldAck  = 1'b0;
        cpuAck = 1'b0;
        if (state_q == S_ISSUE) begin
            rfsh = (gnt_q == G_RF);
            rd   = (gnt_q == G_CRD);
            wr   = (gnt_q == G_INI) | (gnt_q == G_LD)
                 | ((gnt_q == G_CWR) & ~sup_q);
        end
        if (state_q == S_ACK) begin
            iniAck = (gnt_q == G_INI);
            ldAck  = (gnt_q == G_LD);
            cpuAck = (gnt_q == G_CRD) | (gnt_q == G_CWR);
        end
        a    = a_q;
        d    = d_q;
        cpuQ = cpuq_q;
        busy = (state_q != S_IDLE);
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: directed test of the SDRAM arbiter with hand-computed expectations.
// Inputs are driven right after the falling edge, and outputs are sampled on the falling edge.

module tb_sdram_arbiter;

    logic        clock = 1'b0;
    logic        reset, sdrReady, rfshReq;
    logic        iniReq, ldReq, cpuRd, cpuWr;
    logic [21:0] iniA, ldA, cpuA;
    logic [7:0]  iniD, ldD, cpuD, romTop, cpuQ;
    logic        iniAck, ldAck, cpuAck, rfsh, rd, wr, busy;
    logic [23:0] a;
    logic [15:0] d, q;

    int errs = 0;
    int checks = 0;

    localparam int SRD = 0, SWR = 1, SRF = 2, SCA = 3, SIA = 4, SLA = 5;

    sdram_arbiter dut (
        .clock(clock), .reset(reset), .sdrReady(sdrReady), .rfshReq(rfshReq),
        .iniReq(iniReq), .iniA(iniA), .iniD(iniD), .iniAck(iniAck),
        .ldReq(ldReq), .ldA(ldA), .ldD(ldD), .ldAck(ldAck),
        .cpuRd(cpuRd), .cpuWr(cpuWr), .cpuA(cpuA), .cpuD(cpuD),
        .cpuQ(cpuQ), .cpuAck(cpuAck), .romTop(romTop),
        .rfsh(rfsh), .rd(rd), .wr(wr), .a(a), .d(d), .q(q), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            SRD:     return rd;
            SWR:     return wr;
            SRF:     return rfsh;
            SCA:     return cpuAck;
            SIA:     return iniAck;
            default: return ldAck;
        endcase
    endfunction

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clock);
    endtask

    // Cycles until the selected signal is seen high (-1 if never within maxc)
    task automatic wait_sig(input int sel, input int maxc, output int cyc);
        cyc = -1;
        for (int i = 1; i <= maxc && cyc < 0; i++) begin
            @(negedge clock);
            if (sig(sel)) cyc = i;
        end
    endtask

    task automatic count_sig(input int sel, input int n, output int c);
        c = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            if (sig(sel)) c++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c, c2, wc, ap, n, d3;
        int ev[5];

        reset = 1'b1; sdrReady = 1'b1; rfshReq = 1'b0;
        iniReq = 1'b0; ldReq = 1'b0; cpuRd = 1'b0; cpuWr = 1'b0;
        iniA = '0; ldA = '0; cpuA = '0; iniD = '0; ldD = '0; cpuD = '0;
        romTop = 8'h00; q = 16'h0000;
        tick(3);
        reset = 1'b0;
        tick(1);
        check("rst_busy", busy, 0);
        check("rst_strb", {rfsh, rd, wr}, 0);
        check("rst_acks", {iniAck, ldAck, cpuAck}, 0);
        check("rst_a", a, 0);
        check("rst_d", d, 0);
        check("rst_cpuQ", cpuQ, 8'hFF);

        // Basic CPU read
        cpuRd = 1'b1; cpuA = 22'h0ABCDE; q = 16'h0055;
        wait_sig(SRD, 8, c);
        check("rd_lat", c, 1);
        check("rd_a", a, 24'h0ABCDE);
        wait_sig(SCA, 8, c);
        check("rd_ack_lat", c, 4);
        check("rd_cpuQ", cpuQ, 8'h55);
        cpuRd = 1'b0;
        tick(2);

        // Late deassert: request held through the masked cycle
        cpuRd = 1'b1; cpuA = 22'h000100; q = 16'h00A5;
        wait_sig(SCA, 10, c);
        check("mask_ack_lat", c, 5);
        tick(1);
        check("mask_idle", busy, 0);
        cpuRd = 1'b0;
        count_sig(SRD, 8, c);
        check("mask_no_regrant", c, 0);
        check("mask_cpuQ", cpuQ, 8'hA5);

        // sdrReady gating, and a fall mid-slot
        sdrReady = 1'b0; cpuRd = 1'b1; cpuA = 22'h000110;
        count_sig(SRD, 6, c);
        check("nrdy_no_rd", c, 0);
        sdrReady = 1'b1;
        wait_sig(SRD, 4, c);
        check("rdy_rd_lat", c, 1);
        sdrReady = 1'b0;
        wait_sig(SCA, 8, c);
        check("rdy_fall_ack", c, 4);
        cpuRd = 1'b0;
        count_sig(SRD, 6, c);
        check("rdy_low_hold", c, 0);
        sdrReady = 1'b1;
        tick(2);

        // Init, download and CPU write together
        iniReq = 1'b1; iniA = 22'h000010; iniD = 8'h11;
        ldReq = 1'b1; ldA = 22'h200020; ldD = 8'h22;
        cpuWr = 1'b1; cpuA = 22'h3FFFFF; cpuD = 8'h33;
        wait_sig(SWR, 4, c);
        check("ini_wr_lat", c, 1);
        check("ini_a", a, 24'h000010);
        check("ini_d", d, 16'h0011);
        wait_sig(SIA, 8, c);
        check("ini_ack", c, 4);
        iniReq = 1'b0;
        wait_sig(SWR, 4, c);
        check("ld_wr_lat", c, 2);
        check("ld_a", a, 24'h200020);
        check("ld_d", d, 16'h0022);
        wait_sig(SLA, 8, c);
        check("ld_ack", c, 4);
        ldReq = 1'b0;
        wait_sig(SWR, 4, c);
        check("cw_wr_lat", c, 2);
        check("cw_a", a, 24'h3FFFFF);
        check("cw_d", d, 16'h0033);
        wait_sig(SCA, 8, c);
        check("cw_ack", c, 4);
        cpuWr = 1'b0;
        tick(2);

        // Read and write together: handled as a write
        cpuRd = 1'b1; cpuWr = 1'b1; cpuA = 22'h000200; cpuD = 8'h44;
        q = 16'h00EE;
        wc = 0; c2 = 0; ap = 0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clock);
            if (wr) wc++;
            if (rd) c2++;
            if (cpuAck) ap = i;
        end
        check("rw_wr", wc, 1);
        check("rw_no_rd", c2, 0);
        check("rw_ack", ap, 5);
        check("rw_cpuQ_keep", cpuQ, 8'hA5);
        cpuRd = 1'b0; cpuWr = 1'b0;
        tick(2);

        // Refresh deferral with a continuous CPU read
        cpuRd = 1'b1; cpuA = 22'h000300; q = 16'h0077;
        wait_sig(SRD, 4, c);
        check("df_first_rd", c, 1);
        rfshReq = 1'b1;
        tick(1);
        rfshReq = 1'b0;
        n = 0; d3 = -1;
        for (int i = 0; i < 60 && n < 5; i++) begin
            @(negedge clock);
            if (rd || rfsh) begin
                ev[n] = rfsh ? 2 : 1;
                n++;
                if (n == 3) d3 = int'(dut.defer_q);
            end
        end
        check("df_events", n, 5);
        check("df_seq", {ev[0][3:0], ev[1][3:0], ev[2][3:0], ev[3][3:0],
                         ev[4][3:0]}, 20'h11121);
        check("df_max", d3, 3);
        cpuRd = 1'b0;
        wait_sig(SCA, 8, c);
        check("df_last_ack", c, 4);
        tick(2);
        check("df_clear", int'(dut.defer_q), 0);
        check("df_pend", dut.rpend_q, 0);

        // Two refresh ticks during one CPU slot coalesce
        cpuRd = 1'b1; cpuA = 22'h000400;
        wait_sig(SRD, 4, c);
        rfshReq = 1'b1; tick(1);
        rfshReq = 1'b0; tick(1);
        rfshReq = 1'b1; tick(1);
        rfshReq = 1'b0;
        wait_sig(SCA, 4, c);
        check("co_ack", c, 1);
        cpuRd = 1'b0;
        count_sig(SRF, 15, c);
        check("co_one_rfsh", c, 1);

        // Reset during WAIT
        cpuRd = 1'b1; cpuA = 22'h000500; q = 16'h0099;
        wait_sig(SRD, 4, c);
        tick(1);
        reset = 1'b1;
        count_sig(SCA, 1, c);
        reset = 1'b0; cpuRd = 1'b0;
        check("rs_busy", busy, 0);
        check("rs_cpuQ", cpuQ, 8'hFF);
        count_sig(SCA, 8, c2);
        check("rs_no_ack", c + c2, 0);

        // CPU write into ROM page 7 and page 8
        romTop = 8'h07; cpuWr = 1'b1; cpuA = 22'h01C000; cpuD = 8'h5A;
        wc = 0; ap = 0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clock);
            if (wr) wc++;
            if (cpuAck) ap = i;
        end
`ifdef ARB_WPROT_EN
        check("wp_blocked", wc, 0);
`else
        check("wp_off_wr", wc, 1);
`endif
        check("wp_ack", ap, 5);
        cpuWr = 1'b0;
        tick(2);
        cpuWr = 1'b1; cpuA = 22'h020000;
        wc = 0; ap = 0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clock);
            if (wr) wc++;
            if (cpuAck) ap = i;
        end
        check("wp_pg8_wr", wc, 1);
        check("wp_pg8_ack", ap, 5);
        cpuWr = 1'b0;
        tick(2);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
